// File: rtl/rot_frame_packer.sv
// Buffers two-beat encoder samples and re-emits them as headered AXIS frames.
// Optional idle-flush short frames: define ROT_FRAME_PACKER_TIMEOUT_EN.
module rot_frame_packer #(
    parameter int ID                = 0,
    parameter int SAMPLES_PER_FRAME = 16,
    parameter int FIFO_AW           = 6,
    parameter int TIMEOUT_CYCLES    = 50000
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] drop_count,
    output logic [15:0] proto_err_count,
    output logic        overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SPF_C   = CW'(SAMPLES_PER_FRAME);
    localparam logic [15:0]   SPF_N   = 16'(SAMPLES_PER_FRAME);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_TS,
        S_POS
    } state_e;

    logic              tready_q, tready_d;
    logic              phase_q, phase_d;
    logic [31:0]       ts_q, ts_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       perr_q, perr_d;
    logic              ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       rem_q, rem_d;
    logic [31:0]       seq_q, seq_d;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] head;
    logic [63:0] wr_data;
    logic        wr_en;
    logic        pop;
    logic        beat;
    logic        full;
    logic        acc;

`ifdef ROT_FRAME_PACKER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] idle_q, idle_d;
    logic        partial;

    assign partial = (count_q != '0) && (count_q < SPF_C);

    always_comb begin
        idle_d = '0;
        if (state_q == S_IDLE && partial && idle_q != TO_LAST) begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    assign beat    = s_axis_tvalid && tready_q;
    assign full    = (count_q == DEPTH_C);
    assign wr_data = {ts_q, s_axis_tdata};
    assign head    = mem_q[rd_ptr_q];

    // Input assembler: pairs a timestamp beat with the following position beat.
    always_comb begin
        tready_d = 1'b1;
        phase_d  = phase_q;
        ts_d     = ts_q;
        drop_d   = drop_q;
        perr_d   = perr_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        if (beat) begin
            if (!phase_q) begin
                if (s_axis_tlast) begin
                    if (perr_q != 16'hFFFF) perr_d = perr_q + 16'd1;
                end else begin
                    ts_d    = s_axis_tdata;
                    phase_d = 1'b1;
                end
            end else if (s_axis_tlast) begin
                phase_d = 1'b0;
                if (full) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end else begin
                if (perr_q != 16'hFFFF) perr_d = perr_q + 16'd1;
                ts_d = s_axis_tdata;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        count_d = count_q + CW'(wr_en) - CW'(pop);
    end

    assign m_axis_tvalid = (state_q != S_IDLE);
    assign acc = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q >= SPF_C) begin
                    n_d     = SPF_N;
                    rem_d   = SPF_N;
                    state_d = S_HDR0;
                end
`ifdef ROT_FRAME_PACKER_TIMEOUT_EN
                else if (partial && idle_q == TO_LAST) begin
                    n_d     = 16'(count_q);
                    rem_d   = 16'(count_q);
                    state_d = S_HDR0;
                end
`endif
            end
            S_HDR0: if (acc) state_d = S_HDR1;
            S_HDR1: if (acc) state_d = S_TS;
            S_TS:   if (acc) state_d = S_POS;
            S_POS: begin
                if (acc) begin
                    pop   = 1'b1;
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_IDLE;
                        seq_d   = seq_q + 32'd1;
                    end else begin
                        state_d = S_TS;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata = '0;
        unique case (state_q)
            S_HDR0:  m_axis_tdata = {8'hA5, 8'(ID), n_q};
            S_HDR1:  m_axis_tdata = seq_q;
            S_TS:    m_axis_tdata = head[63:32];
            S_POS:   m_axis_tdata = head[31:0];
            default: m_axis_tdata = '0;
        endcase
    end

    assign m_axis_tlast    = (state_q == S_POS) && (rem_q == 16'd1);
    assign s_axis_tready   = tready_q;
    assign drop_count      = drop_q;
    assign proto_err_count = perr_q;
    assign overflow        = ovf_q;

    // Storage array needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tready_q <= 1'b0;
            phase_q  <= 1'b0;
            ts_q     <= '0;
            drop_q   <= '0;
            perr_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            n_q      <= '0;
            rem_q    <= '0;
            seq_q    <= '0;
        end else begin
            tready_q <= tready_d;
            phase_q  <= phase_d;
            ts_q     <= ts_d;
            drop_q   <= drop_d;
            perr_q   <= perr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            n_q      <= n_d;
            rem_q    <= rem_d;
            seq_q    <= seq_d;
        end
    end

endmodule

// File: tb/tb_rot_frame_packer.sv
// Directed bench for rot_frame_packer: framing, stalls, overflow,
// protocol errors, mid-frame reset and idle flush.
module tb_rot_frame_packer;

    logic        clk = 1'b0;
    logic        arstn = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic [15:0] drop_count;
    logic [15:0] proto_err_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [32:0] got[$];
    logic [32:0] exp_q[$];
    logic [63:0] mdl[$];

    bit          rand_rdy = 1'b0;
    bit          mon_stall = 1'b0;
    bit          mon_last = 1'b0;
    logic [32:0] mon_prev = '0;

    rot_frame_packer #(
        .ID(0),
        .SAMPLES_PER_FRAME(16),
        .FIFO_AW(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .arstn(arstn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .drop_count(drop_count),
        .proto_err_count(proto_err_count),
        .overflow(overflow)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_axis_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Output monitor: records accepted beats, checks stall hold and frame gap.
    always @(negedge clk) begin
        if (!arstn) begin
            mon_stall = 1'b0;
            mon_last  = 1'b0;
        end else begin
            if (mon_stall) begin
                checks++;
                assert (m_axis_tvalid === 1'b1 &&
                        {m_axis_tlast, m_axis_tdata} === mon_prev)
                else begin
                    failures++;
                    $error("FAIL stall_hold got v=%0b %h exp v=1 %h",
                           m_axis_tvalid, {m_axis_tlast, m_axis_tdata},
                           mon_prev);
                end
            end
            if (mon_last) begin
                checks++;
                assert (m_axis_tvalid === 1'b0)
                else begin
                    failures++;
                    $error("FAIL frame_gap got tvalid=%0b exp 0",
                           m_axis_tvalid);
                end
            end
            mon_stall = m_axis_tvalid && !m_axis_tready;
            mon_prev  = {m_axis_tlast, m_axis_tdata};
            mon_last  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready)
                got.push_back({m_axis_tlast, m_axis_tdata});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] ts, input logic [31:0] pos,
                               input bit keep);
        send_beat(ts, 1'b0);
        send_beat(pos, 1'b1);
        if (keep) mdl.push_back({ts, pos});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [31:0] seq, input int n);
        logic [63:0] s;
        exp_q.push_back({1'b0, 8'hA5, 8'h00, 16'(n)});
        exp_q.push_back({1'b0, seq});
        for (int k = 0; k < n; k++) begin
            s = mdl.pop_front();
            exp_q.push_back({1'b0, s[63:32]});
            exp_q.push_back({(k == n - 1), s[31:0]});
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int cyc = 0;
        while (got.size() < n && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int m;
        checks++;
        assert (got.size() == exp_q.size())
        else begin
            failures++;
            $error("FAIL %s_len got=%0d exp=%0d", tag, got.size(),
                   exp_q.size());
        end
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            assert (got[i] === exp_q[i])
            else begin
                failures++;
                $error("FAIL %s[%0d] got=%h exp=%h", tag, i, got[i],
                       exp_q[i]);
            end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rand_rdy      = 1'b0;
        m_axis_tready = 1'b0;
        arstn         = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        got.delete();
        exp_q.delete();
        mdl.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int to;
        #3 arstn = 1'b0;
        #2;
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tlast", 32'(m_axis_tlast), 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_perr", 32'(proto_err_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_tready", 32'(s_axis_tready), 0);
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_up", 32'(s_axis_tready), 1);

        // Basic frame
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 16; i++) send_sample(i, 100 + i, 1'b1);
        wait_beats(34, 200);
        expect_frame(0, 16);
        compare("basic");
        chk("basic_drop", 32'(drop_count), 0);
        chk("basic_perr", 32'(proto_err_count), 0);
        chk("basic_idle", 32'(m_axis_tvalid), 0);

        // Backpressure
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 1; i <= 32; i++) send_sample(200 + i, 300 + i, 1'b1);
        wait_beats(68, 800);
        expect_frame(0, 16);
        expect_frame(1, 16);
        compare("bp");

        // Overflow
        do_reset();
        for (int i = 1; i <= 70; i++) send_sample(i, 1000 + i, (i <= 64));
        chk("ovf_drop", 32'(drop_count), 6);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_stall_v", 32'(m_axis_tvalid), 1);
        chk("ovf_stall_d", m_axis_tdata, 32'hA5000010);
        m_axis_tready = 1'b1;
        wait_beats(136, 600);
        for (int f = 0; f < 4; f++) expect_frame(f, 16);
        chk("ovf_last_pos", got[got.size() - 1][31:0], 1064);
        compare("ovf");
        chk("ovf_sticky", 32'(overflow), 1);

        // Protocol errors
        do_reset();
        m_axis_tready = 1'b1;
        send_beat(32'hDEAD, 1'b1);
        send_beat(5, 1'b0);
        send_beat(6, 1'b0);
        send_beat(200, 1'b1);
        mdl.push_back({32'd6, 32'd200});
        chk("perr_count", 32'(proto_err_count), 2);
        for (int i = 1; i <= 15; i++) send_sample(i, 400 + i, 1'b1);
        wait_beats(34, 200);
        expect_frame(0, 16);
        compare("perr");

        // Reset mid-frame, during beat 10
        do_reset();
        for (int i = 1; i <= 16; i++) send_sample(i, 500 + i, 1'b0);
        m_axis_tready = 1'b1;
        to = 0;
        while (got.size() != 9 && to < 200) begin
            @(posedge clk);
            #1;
            to++;
        end
        chk("mid_reached", 32'(got.size()), 9);
        arstn = 1'b0;
        #1;
        chk("mid_async_v", 32'(m_axis_tvalid), 0);
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        got.delete();
        mdl.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_resume", 32'(got.size()), 0);
        for (int i = 1; i <= 16; i++) send_sample(50 + i, 600 + i, 1'b1);
        wait_beats(34, 200);
        expect_frame(0, 16);
        compare("mid");

        // Idle flush
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 3; i++) send_sample(70 + i, 700 + i, 1'b1);
`ifdef ROT_FRAME_PACKER_TIMEOUT_EN
        wait_beats(8, 400);
        expect_frame(0, 3);
        compare("timeout");
`else
        repeat (300) @(posedge clk);
        #1;
        chk("no_timeout_beats", 32'(got.size()), 0);
        chk("no_timeout_v", 32'(m_axis_tvalid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
